// File: rtl/spi_crc_engine.sv
// spi_crc_engine: streaming CRC7/CRC16 generator and checker for the SPI/SD datapath.
// Optional word-count check against BLOCK_LEN is built when SPI_CRC_LEN_CHECK_EN is defined.
module spi_crc_engine #(
    parameter int               CRC_W     = 16,
    parameter logic [CRC_W-1:0] POLY      = 16'h1021,
    parameter logic [CRC_W-1:0] INIT      = '0,
    parameter int               DATA_W    = 8,
    parameter int               CNT_W     = 10,
    parameter int               BLOCK_LEN = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              finish,
    input  logic              check_mode,
    output logic [CRC_W-1:0]  crc_out,
    output logic [DATA_W-1:0] crc_word,
    output logic              crc_word_valid,
    input  logic              crc_word_ready,
    output logic [CNT_W-1:0]  word_count,
    output logic              done,
    output logic              crc_ok,
    output logic              len_err
);
    localparam int F       = (CRC_W + DATA_W - 1) / DATA_W;
    localparam int FRAME_W = F * DATA_W;
    localparam int IDX_W   = (F > 1) ? $clog2(F) : 1;

    localparam logic [1:0] ST_ACC   = 2'd0;
    localparam logic [1:0] ST_EMIT  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // DATA_W serial LFSR steps, MSB of the word first, no reflection.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                  input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ d[i];
            c  = c << 1;
            if (fb) c = c ^ POLY;
        end
        return c;
    endfunction

    // CRC left-aligned in the frame, unused LSBs padded with ones.
    function automatic logic [FRAME_W-1:0] frame_pack(input logic [CRC_W-1:0] crc);
        logic [FRAME_W-1:0] f;
        f = '1;
        f[FRAME_W-1 -: CRC_W] = crc;
        return f;
    endfunction

    logic [1:0]         state;
    logic [CRC_W-1:0]   lfsr;
    logic [FRAME_W-1:0] frame_q;
    logic [IDX_W-1:0]   idx_q;
    logic               err_q;

    logic               in_acc;
    logic [CRC_W-1:0]   lfsr_abs;
    logic [CNT_W-1:0]   cnt_abs;
    logic [DATA_W-1:0]  top_word;
    logic               last_idx;
    logic               mismatch;

    assign in_acc         = (state == ST_ACC);
    assign data_ready     = in_acc || (state == ST_CHECK);
    assign crc_word_valid = (state == ST_EMIT);
    assign done           = (state == ST_DONE);
    assign top_word       = frame_q[FRAME_W-1 -: DATA_W];
    assign crc_word       = top_word;
    assign last_idx       = (idx_q == IDX_W'(F - 1));
    assign mismatch       = (data_in != top_word);

    // A word presented together with finish is absorbed before the snapshot.
    assign lfsr_abs = (in_acc && data_valid) ? crc_step(lfsr, data_in) : lfsr;
    assign cnt_abs  = (in_acc && data_valid && (word_count != '1)) ? word_count + 1'b1
                                                                   : word_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ACC;
            lfsr       <= INIT;
            crc_out    <= '0;
            frame_q    <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            word_count <= '0;
            crc_ok     <= 1'b0;
        end else if (clr) begin
            state      <= ST_ACC;
            lfsr       <= INIT;
            idx_q      <= '0;
            err_q      <= 1'b0;
            word_count <= '0;
            crc_ok     <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    lfsr       <= lfsr_abs;
                    word_count <= cnt_abs;
                    if (finish) begin
                        crc_out <= lfsr_abs;
                        frame_q <= frame_pack(lfsr_abs);
                        crc_ok  <= 1'b0;
                        idx_q   <= '0;
                        err_q   <= 1'b0;
                        state   <= check_mode ? ST_CHECK : ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (crc_word_ready) begin
                        frame_q <= frame_q << DATA_W;
                        idx_q   <= idx_q + 1'b1;
                        if (last_idx) state <= ST_DONE;
                    end
                end
                ST_CHECK: begin
                    if (data_valid) begin
                        frame_q <= frame_q << DATA_W;
                        idx_q   <= idx_q + 1'b1;
                        err_q   <= err_q | mismatch;
                        if (last_idx) begin
                            crc_ok <= !(err_q || mismatch) && !len_err;
                            state  <= ST_DONE;
                        end
                    end
                end
                default: begin
                    lfsr       <= INIT;
                    word_count <= '0;
                    state      <= ST_ACC;
                end
            endcase
        end
    end

`ifdef SPI_CRC_LEN_CHECK_EN
    logic len_err_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            len_err_q <= 1'b0;
        end else if (in_acc && finish) begin
            len_err_q <= (cnt_abs != CNT_W'(BLOCK_LEN));
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_crc_engine.sv
// Bench for spi_crc_engine: a CRC7 and a CRC16 instance checked against a long-division CRC model.
module tb_spi_crc_engine;
`ifdef SPI_CRC_LEN_CHECK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, clr, dv, fin, cmode, rdy, sel;
    logic [7:0] data_in;

    logic       dr7, cwv7, done7, ok7, le7;
    logic [6:0] crc7;
    logic [7:0] cw7;
    logic [9:0] wc7;
    logic       dr16, cwv16, done16, ok16, le16;
    logic [15:0] crc16;
    logic [7:0] cw16;
    logic [9:0] wc16;

    logic       o_dr, o_cwv, o_done, o_ok, o_le;
    logic [15:0] o_crc;
    logic [7:0] o_cw;
    logic [9:0] o_wc;

    int checks = 0;
    int failures = 0;
    int cur_w, cur_f;
    logic [16:0] cur_gen;
    byte unsigned msg_q[$];
    logic [7:0] last_word;
    logic [15:0] last_crc;

    always #5 clk = ~clk;

    spi_crc_engine #(.CRC_W(7), .POLY(7'h09)) u_crc7 (
        .clk(clk), .rst(rst), .clr(clr), .data_in(data_in),
        .data_valid(dv & ~sel), .data_ready(dr7), .finish(fin & ~sel), .check_mode(cmode),
        .crc_out(crc7), .crc_word(cw7), .crc_word_valid(cwv7), .crc_word_ready(rdy & ~sel),
        .word_count(wc7), .done(done7), .crc_ok(ok7), .len_err(le7)
    );

    spi_crc_engine u_crc16 (
        .clk(clk), .rst(rst), .clr(clr), .data_in(data_in),
        .data_valid(dv & sel), .data_ready(dr16), .finish(fin & sel), .check_mode(cmode),
        .crc_out(crc16), .crc_word(cw16), .crc_word_valid(cwv16), .crc_word_ready(rdy & sel),
        .word_count(wc16), .done(done16), .crc_ok(ok16), .len_err(le16)
    );

    always_comb begin
        o_dr   = sel ? dr16 : dr7;
        o_cwv  = sel ? cwv16 : cwv7;
        o_done = sel ? done16 : done7;
        o_ok   = sel ? ok16 : ok7;
        o_le   = sel ? le16 : le7;
        o_crc  = sel ? crc16 : {9'd0, crc7};
        o_cw   = sel ? cw16 : cw7;
        o_wc   = sel ? wc16 : wc7;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_sel(input logic s);
        sel     = s;
        cur_w   = s ? 16 : 7;
        cur_f   = s ? 2 : 1;
        cur_gen = s ? 17'h11021 : 17'h00089;
    endtask

    // Remainder of message(x) * x^w divided by the full generator polynomial.
    function automatic logic [15:0] ref_crc();
        bit bits[$];
        byte unsigned v;
        logic [15:0] r;
        foreach (msg_q[i]) begin
            v = msg_q[i];
            for (int b = 7; b >= 0; b--) bits.push_back(v[b]);
        end
        repeat (cur_w) bits.push_back(1'b0);
        for (int i = 0; i + cur_w < bits.size(); i++)
            if (bits[i])
                for (int j = 0; j <= cur_w; j++) bits[i+j] = bits[i+j] ^ cur_gen[cur_w-j];
        r = '0;
        for (int i = 0; i < cur_w; i++) r = {r[14:0], bits[bits.size()-cur_w+i]};
        return r;
    endfunction

    function automatic logic [7:0] fw(input logic [15:0] fr, input int k);
        if (cur_f == 1 || k != 0) return fr[7:0];
        return fr[15:8];
    endfunction

    task automatic absorb(input bit cm, input bit fin_last);
        for (int i = 0; i < msg_q.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                dv = 1'b0; fin = 1'b0;
                @(posedge clk); #1;
            end
            data_in = msg_q[i];
            dv      = 1'b1;
            cmode   = cm;
            fin     = fin_last && (i == msg_q.size() - 1);
            @(posedge clk); #1;
        end
        dv = 1'b0;
        if (!fin_last) begin
            fin = 1'b1; cmode = cm;
            @(posedge clk); #1;
        end
        fin = 1'b0;
    endtask

    task automatic emit_collect(input logic [15:0] fr, input bit tog);
        int idx = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [7:0] held = '0;
        while (idx < cur_f && cyc < 64) begin
            chk("emit_valid", o_cwv, 1);
            if (stalled) chk("emit_stable", o_cw, held);
            rdy     = tog ? cyc[0] : 1'($urandom_range(0, 1));
            dv      = 1'($urandom_range(0, 1));
            fin     = 1'($urandom_range(0, 1));
            data_in = 8'($urandom);
            if (rdy) begin
                chk("emit_word", o_cw, fw(fr, idx));
                last_word = o_cw;
                idx++;
                stalled = 1'b0;
            end else begin
                held    = o_cw;
                stalled = 1'b1;
            end
            cyc++;
            @(posedge clk); #1;
        end
        rdy = 1'b0; dv = 1'b0; fin = 1'b0;
        chk("emit_complete", idx, cur_f);
    endtask

    task automatic check_feed(input logic [15:0] fr, input bit corrupt);
        for (int k = 0; k < cur_f; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                dv = 1'b0;
                @(posedge clk); #1;
            end
            chk("check_ready", o_dr, 1);
            data_in = fw(fr, k) ^ ((corrupt && k == cur_f - 1) ? 8'h01 : 8'h00);
            dv = 1'b1;
            @(posedge clk); #1;
        end
        dv = 1'b0;
    endtask

    task automatic run_frame(input bit cm, input bit fin_last, input bit corrupt, input bit tog);
        logic [15:0] c, fr;
        logic exp_le, exp_ok;
        int n;
        n  = msg_q.size();
        c  = ref_crc();
        fr = (cur_w == 7) ? {8'h00, c[6:0], 1'b1} : c;
        exp_le = LEN_EN && (n != 512);
        absorb(cm, fin_last);
        chk("fin_crc_out", o_crc, c);
        chk("fin_word_count", o_wc, n);
        chk("fin_len_err", o_le, exp_le);
        chk("fin_word_valid", o_cwv, !cm);
        chk("fin_crc_ok_cleared", o_ok, 0);
        if (!cm) begin
            emit_collect(fr, tog);
            exp_ok = 1'b0;
        end else begin
            check_feed(fr, corrupt);
            exp_ok = !corrupt && !exp_le;
        end
        chk("done_pulse", o_done, 1);
        chk("done_ready", o_dr, 0);
        chk("done_crc_ok", o_ok, exp_ok);
        chk("done_word_count", o_wc, n);
        @(posedge clk); #1;
        chk("post_done_low", o_done, 0);
        chk("post_word_count", o_wc, 0);
        chk("post_crc_out_hold", o_crc, c);
        chk("post_crc_ok_hold", o_ok, exp_ok);
        last_crc = c;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c;
        rst = 1'b1; clr = 1'b0; dv = 1'b0; fin = 1'b0; cmode = 1'b0; rdy = 1'b0;
        data_in = '0;
        last_word = '0; last_crc = '0;
        set_sel(1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state of both instances
        chk("rst_crc16", crc16, 0);
        chk("rst_crc7", crc7, 0);
        chk("rst_word", cw16, 0);
        chk("rst_valid", cwv16 | cwv7, 0);
        chk("rst_count", wc16, 0);
        chk("rst_done", done16 | done7, 0);
        chk("rst_ok", ok16 | ok7, 0);
        chk("rst_len_err", le16 | le7, 0);
        chk("rst_ready", dr16 & dr7, 1);

        // CRC7 command frames
        set_sel(1'b0);
        msg_q = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(1'b0, 1'b1, 1'b0, 1'b0);
        chk("cmd0_crc", o_crc, 16'h004A);
        chk("cmd0_word", last_word, 8'h95);
        msg_q = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA};
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk("cmd8_word", last_word, 8'h87);
        msg_q = '{8'h51, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(1'b0, 1'b1, 1'b0, 1'b0);
        chk("cmd17_word", last_word, 8'h55);

        // CRC16 data block, emit with toggling ready
        set_sel(1'b1);
        msg_q.delete();
        repeat (512) msg_q.push_back(8'hFF);
        run_frame(1'b0, 1'b1, 1'b0, 1'b1);
        chk("blk_crc", o_crc, 16'h7FA1);
        chk("blk_last_word", last_word, 8'hA1);

        // CRC16 check: correct, then corrupted second word
        run_frame(1'b1, 1'b1, 1'b0, 1'b0);
        chk("blk_check_ok", o_ok, 1);
        run_frame(1'b1, 1'b0, 1'b1, 1'b0);
        chk("blk_check_bad", o_ok, 0);

        // short block: length error only when the feature is built
        msg_q.delete();
        repeat (511) msg_q.push_back(8'hFF);
        run_frame(1'b1, 1'b1, 1'b0, 1'b0);

        // clr after first emitted word
        msg_q.delete();
        repeat (10) msg_q.push_back(8'($urandom));
        c = ref_crc();
        absorb(1'b0, 1'b1);
        chk("clr_pre_valid", o_cwv, 1);
        rdy = 1'b1;
        @(posedge clk); #1;
        chk("clr_second_pending", o_cwv, 1);
        rdy = 1'b0; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr_valid", o_cwv, 0);
        chk("clr_done", o_done, 0);
        chk("clr_count", o_wc, 0);
        chk("clr_crc_kept", o_crc, c);
        chk("clr_ok", o_ok, 0);
        chk("clr_len_err", o_le, 0);
        @(posedge clk); #1;
        chk("clr_no_done", o_done, 0);
        set_sel(1'b0);
        msg_q = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(1'b0, 1'b1, 1'b0, 1'b0);
        chk("clr_cmd0_word", last_word, 8'h95);

        // randomized frames on both widths and modes
        for (int t = 0; t < 10; t++) begin
            set_sel(1'($urandom_range(0, 1)));
            msg_q.delete();
            repeat ($urandom_range(1, 24)) msg_q.push_back(8'($urandom));
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
